// File: rtl/qracc_pkg.sv
// Shared types and constants for the QR-ACC bit-serial MAC sequencer and its array wrapper.
package qracc_pkg;
  localparam int numRows    = 128;
  localparam int numCols    = 32;
  localparam int numAdcBits = 4;
  localparam int numCfgBits = 8;

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, COMMIT} mac_state_t;

  typedef struct packed {
    logic [3:0] n_bits;
    logic       signed_mode;
    logic [2:0] adc_ref_range_shifts;
  } qracc_config_t;

  typedef struct packed {
    logic               mac_en;
    logic [numRows-1:0] data_p_i;
    logic [numRows-1:0] data_n_i;
  } to_analog_t;

  typedef struct packed {
    logic [numCols-1:0][numAdcBits-1:0] adc_out;
  } from_analog_t;

  typedef struct packed {
    logic               req;
    logic [numCols-1:0] data;
  } to_sram_t;

  typedef struct packed {
    logic               ack;
    logic [numCols-1:0] data;
  } from_sram_t;

  // Effective serial precision: at least 2 bits so a signed MSB always has a partner bit.
  function automatic int n_eff_of(input logic [3:0] n_bits, input int max_bits);
    int n;
    n = int'(n_bits);
    if (n < 2) return 2;
    if (n > max_bits) return max_bits;
    return n;
  endfunction
endpackage

// File: rtl/bitserial_piso.sv
// Parallel-in serial-out buffer: latches one input vector and presents the selected bit of every element.
module bitserial_piso #(
  parameter int numElements = 128,
  parameter int numBits     = 8,
  parameter int idxW        = 3
) (
  input  logic                                clk,
  input  logic                                nrst,
  input  logic                                load,
  input  logic [numElements-1:0][numBits-1:0] data_i,
  input  logic [idxW-1:0]                     idx_i,
  output logic [numElements-1:0]              bits_o
);
  logic [numElements-1:0][numBits-1:0] buf_q, buf_d;

  always_comb begin
    buf_d = load ? data_i : buf_q;
    for (int e = 0; e < numElements; e++) bits_o[e] = buf_q[e][idx_i];
  end

  always_ff @(posedge clk) begin
    if (!nrst) buf_q <= '0;
    else       buf_q <= buf_d;
  end
endmodule

// File: rtl/qr_acc_wrapper.sv
// Array wrapper: routes serial drive bits to the analog macro and ADC codes back to the sequencer.
module qr_acc_wrapper
  import qracc_pkg::*;
(
  input  logic                               mac_en,
  input  logic [numRows-1:0]                 data_p_i,
  input  logic [numRows-1:0]                 data_n_i,
  output logic [numCols-1:0][numAdcBits-1:0] adc_out,
  output to_analog_t                         to_analog_o,
  input  from_analog_t                       from_analog_i,
  output from_sram_t                         from_sram,
  input  to_sram_t                           to_sram
);
  assign to_analog_o = '{mac_en: mac_en, data_p_i: data_p_i, data_n_i: data_n_i};
  assign adc_out     = from_analog_i.adc_out;
  assign from_sram   = '{ack: to_sram.req, data: to_sram.data};
endmodule

// File: rtl/bitserial_mac_seq.sv
// Bit-serial MAC sequencer: streams an input vector MSB-first into the analog array and
// shift-accumulates the per-column ADC codes into a held output buffer.
module bitserial_mac_seq
  import qracc_pkg::*;
#(
  parameter int maxInputBits    = 8,
  parameter int inputElements   = numRows,
  parameter int outputElements  = numCols,
  parameter int adcBits         = numAdcBits,
  parameter int accumulatorBits = 16,
  parameter int adcLatency      = 1
) (
  input  logic                                             clk,
  input  logic                                             nrst,
  input  qracc_config_t                                    cfg,
  input  logic [inputElements-1:0][maxInputBits-1:0]       mac_data_i,
  input  logic                                             mac_valid_i,
  output logic                                             ready_o,
  output logic                                             valid_o,
  input  logic                                             ready_i,
  output logic [outputElements-1:0][accumulatorBits-1:0]   mac_data_o,
  output to_analog_t                                       to_analog_o,
  input  from_analog_t                                     from_analog_i,
  output from_sram_t                                       from_sram,
  input  to_sram_t                                         to_sram
);
  localparam int idxW = (maxInputBits > 1) ? $clog2(maxInputBits) : 1;

  mac_state_t                                       state_q, state_d;
  logic [idxW-1:0]                                  idx_q, idx_d, top_q, top_d;
  logic                                             sgn_q, sgn_d, first_q, first_d;
  logic [2:0]                                       shift_q, shift_d;
  logic [adcLatency-1:0]                            sv_q, sv_d;
  logic [1:0]                                       drain_q, drain_d;
  logic [outputElements-1:0][accumulatorBits-1:0]   acc_q, acc_d, out_q, out_d, adc_ext;
  logic                                             valid_q, valid_d, ready_q, ready_d;
  logic                                             mac_en_q, mac_en_d;
  logic [inputElements-1:0]                         bits, data_p, data_n;
  logic [outputElements-1:0][adcBits-1:0]           adc_code;
  logic                                             accept;

  assign accept     = mac_valid_i & ready_q;
  assign ready_o    = ready_q;
  assign valid_o    = valid_q;
  assign mac_data_o = out_q;

  bitserial_piso #(
    .numElements(inputElements), .numBits(maxInputBits), .idxW(idxW)
  ) u_piso (
    .clk(clk), .nrst(nrst), .load(accept), .data_i(mac_data_i), .idx_i(idx_q), .bits_o(bits)
  );

  qr_acc_wrapper u_array (
    .mac_en(mac_en_q), .data_p_i(data_p), .data_n_i(data_n), .adc_out(adc_code),
    .to_analog_o(to_analog_o), .from_analog_i(from_analog_i),
    .from_sram(from_sram), .to_sram(to_sram)
  );

  // Signed MSB is driven on the negative line so the array weights it as -2^(n-1).
  always_comb begin
    data_p = '0;
    data_n = '0;
    if (mac_en_q) begin
      if (sgn_q && (idx_q == top_q)) data_n = bits;
      else                           data_p = bits;
    end
  end

  always_comb begin
    for (int c = 0; c < outputElements; c++)
      adc_ext[c] = {{(accumulatorBits-adcBits){adc_code[c][adcBits-1]}}, adc_code[c]};
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    top_d   = top_q;
    sgn_d   = sgn_q;
    shift_d = shift_q;
    first_d = first_q;
    drain_d = drain_q;
    acc_d   = acc_q;
    out_d   = out_q;
    valid_d = valid_q & ~ready_i;
    sv_d    = adcLatency'({sv_q, mac_en_q});

    if (sv_q[adcLatency-1]) begin
      for (int c = 0; c < outputElements; c++)
        acc_d[c] = first_q ? adc_ext[c] : (acc_q[c] << 1) + adc_ext[c];
      first_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          top_d   = idxW'(n_eff_of(cfg.n_bits, maxInputBits) - 1);
          idx_d   = idxW'(n_eff_of(cfg.n_bits, maxInputBits) - 1);
          sgn_d   = cfg.signed_mode;
          shift_d = cfg.adc_ref_range_shifts;
          first_d = 1'b1;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (idx_q == '0) begin
          drain_d = 2'(adcLatency - 1);
          state_d = DRAIN;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      DRAIN: begin
        if (drain_q == 2'd0) state_d = COMMIT;
        else                 drain_d = drain_q - 2'd1;
      end
      COMMIT: begin
        if (!valid_q || ready_i) begin
          for (int c = 0; c < outputElements; c++) out_d[c] = acc_q[c] << shift_q;
          valid_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    mac_en_d = (state_d == STREAM);
    ready_d  = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      top_q    <= '0;
      sgn_q    <= 1'b0;
      shift_q  <= '0;
      first_q  <= 1'b0;
      drain_q  <= '0;
      sv_q     <= '0;
      acc_q    <= '0;
      out_q    <= '0;
      valid_q  <= 1'b0;
      ready_q  <= 1'b1;
      mac_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      top_q    <= top_d;
      sgn_q    <= sgn_d;
      shift_q  <= shift_d;
      first_q  <= first_d;
      drain_q  <= drain_d;
      sv_q     <= sv_d;
      acc_q    <= acc_d;
      out_q    <= out_d;
      valid_q  <= valid_d;
      ready_q  <= ready_d;
      mac_en_q <= mac_en_d;
    end
  end
endmodule

// File: tb/tb_bitserial_mac_seq.sv
// Self-checking bench for bitserial_mac_seq: mock ADC with programmable per-sample codes and a
// weighted-sum reference model.
module tb_bitserial_mac_seq;
  import qracc_pkg::*;

  localparam int MB = 8, NE = 128, NO = 32, ACC = 16, LAT = 1;
  localparam int W = NO * ACC;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   nrst;
  qracc_config_t          cfg;
  logic [NE-1:0][MB-1:0]  din;
  logic                   mac_valid, ready_o, valid_o, ready_i;
  logic [NO-1:0][ACC-1:0] dout;
  to_analog_t             ta;
  from_analog_t           fa;
  from_sram_t             fs;
  to_sram_t               ts;

  qracc_config_t          cfg8;
  logic [NE-1:0][MB-1:0]  din8;
  logic                   mac_valid8, ready8_o, valid8_o, ready8_i;
  logic [NO-1:0][7:0]     dout8;
  to_analog_t             ta8;
  from_analog_t           fa8;
  from_sram_t             fs8;

  bitserial_mac_seq #(
    .maxInputBits(MB), .inputElements(NE), .outputElements(NO),
    .adcBits(4), .accumulatorBits(ACC), .adcLatency(LAT)
  ) dut (
    .clk(clk), .nrst(nrst), .cfg(cfg), .mac_data_i(din), .mac_valid_i(mac_valid),
    .ready_o(ready_o), .valid_o(valid_o), .ready_i(ready_i), .mac_data_o(dout),
    .to_analog_o(ta), .from_analog_i(fa), .from_sram(fs), .to_sram(ts)
  );

  bitserial_mac_seq #(
    .maxInputBits(MB), .inputElements(NE), .outputElements(NO),
    .adcBits(4), .accumulatorBits(8), .adcLatency(LAT)
  ) dut8 (
    .clk(clk), .nrst(nrst), .cfg(cfg8), .mac_data_i(din8), .mac_valid_i(mac_valid8),
    .ready_o(ready8_o), .valid_o(valid8_o), .ready_i(ready8_i), .mac_data_o(dout8),
    .to_analog_o(ta8), .from_analog_i(fa8), .from_sram(fs8), .to_sram(ts)
  );

  // Mock ADC: a code appears LAT=1 cycle after the cycle mac_en was high; junk otherwise.
  int   codes [0:1023][0:NO-1];
  int   samp = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  logic en_seen = 1'b0;

  always @(posedge clk) cyc++;
  always @(negedge clk) en_seen = ta.mac_en;
  always @(posedge clk) begin
    #1;
    for (int c = 0; c < NO; c++) fa.adc_out[c] = en_seen ? 4'(codes[samp % 1024][c]) : 4'd5;
    if (en_seen === 1'b1) samp++;
  end

  int passes = 0, total = 0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) passes = passes + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int n_eff(input int nb);
    return (nb < 2) ? 2 : (nb > MB) ? MB : nb;
  endfunction

  // Result = (sum_k code_k * 2^(n-1-k)) << shifts, modulo 2^ACC.
  function automatic logic [W-1:0] ref_vec(input int base, input int n, input int sh);
    logic [W-1:0] v;
    longint s;
    v = '0;
    for (int c = 0; c < NO; c++) begin
      s = 0;
      for (int k = 0; k < n; k++)
        s += longint'(codes[(base + k) % 1024][c]) * (longint'(1) << (n - 1 - k));
      s = s << sh;
      v[c*ACC +: ACC] = ACC'(s);
    end
    return v;
  endfunction

  task automatic set_seq(input int v0, input int v1, input int v2, input int v3);
    for (int c = 0; c < NO; c++) begin
      codes[(samp + 0) % 1024][c] = v0;
      codes[(samp + 1) % 1024][c] = v1;
      codes[(samp + 2) % 1024][c] = v2;
      codes[(samp + 3) % 1024][c] = v3;
    end
  endtask

  task automatic issue(input int nb, input bit sgn, input int sh,
                       output int base, output logic [NE-1:0][MB-1:0] d);
    int t;
    t = 0;
    while (ready_o !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    chk("ready_wait", W'(ready_o), W'(1'b1));
    cfg.n_bits = 4'(nb);
    cfg.signed_mode = sgn;
    cfg.adc_ref_range_shifts = 3'(sh);
    for (int e = 0; e < NE; e++) d[e] = 8'($urandom);
    din = d;
    mac_valid = 1'b1;
    base = samp;
    @(negedge clk);
    acc_cyc = cyc;
    mac_valid = 1'b0;
    for (int e = 0; e < NE; e++) din[e] = 8'($urandom);
    cfg = 8'($urandom);
  endtask

  task automatic check_stream(input int n, input bit sgn, input logic [NE-1:0][MB-1:0] d);
    logic [NE-1:0] b;
    for (int k = 0; k < n; k++) begin
      for (int e = 0; e < NE; e++) b[e] = d[e][n - 1 - k];
      chk("stream_en", W'(ta.mac_en), W'(1'b1));
      chk("data_p", W'(ta.data_p_i), (sgn && k == 0) ? W'(0) : W'(b));
      chk("data_n", W'(ta.data_n_i), (sgn && k == 0) ? W'(b) : W'(0));
      @(negedge clk);
    end
    chk("stream_end_en", W'(ta.mac_en), W'(1'b0));
    chk("stream_end_data", W'({ta.data_p_i, ta.data_n_i}), W'(0));
  endtask

  task automatic wait_valid(output int lat);
    int t;
    t = 0;
    while (valid_o !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    chk("valid_wait", W'(valid_o), W'(1'b1));
    lat = cyc - acc_cyc;
  endtask

  task automatic run_op(input int nb, input bit sgn, input int sh, output logic [W-1:0] got);
    int base, lat, n;
    logic [NE-1:0][MB-1:0] d;
    n = n_eff(nb);
    issue(nb, sgn, sh, base, d);
    check_stream(n, sgn, d);
    wait_valid(lat);
    chk("latency", W'(lat), W'(n + LAT + 1));
    chk("result", W'(dout), ref_vec(base, n, sh));
    got = dout;
    @(negedge clk);
    chk("valid_clear", W'(valid_o), W'(1'b0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] got, exp_a, exp_b;
    logic [NE-1:0][MB-1:0] da, db;
    int base_a, base_b, lat, t;
    logic seen;

    for (int s = 0; s < 1024; s++)
      for (int c = 0; c < NO; c++) codes[s][c] = int'($urandom_range(15, 0)) - 8;
    nrst = 1'b0; mac_valid = 1'b0; ready_i = 1'b1; cfg = '0; din = '0;
    mac_valid8 = 1'b0; ready8_i = 1'b1; cfg8 = '0; din8 = '0;
    ts = '{req: 1'b0, data: 32'h0};
    for (int c = 0; c < NO; c++) fa8.adc_out[c] = 4'd7;
    repeat (3) @(negedge clk);

    chk("rst_ready", W'(ready_o), W'(1'b1));
    chk("rst_valid", W'(valid_o), W'(1'b0));
    chk("rst_data", W'(dout), W'(0));
    chk("rst_mac_en", W'(ta.mac_en), W'(1'b0));
    nrst = 1'b1;
    @(negedge clk);
    chk("ready_after_release", W'(ready_o), W'(1'b1));

    // Unsigned, all +1 codes
    set_seq(1, 1, 1, 1);
    run_op(4, 1'b0, 0, got);
    chk("unsigned_ones", got, W'({NO{16'd15}}));

    // Signed, codes 3,-1,0,2 with 2 range shifts
    set_seq(3, -1, 0, 2);
    run_op(4, 1'b1, 2, got);
    chk("signed_seq", got, W'({NO{16'd88}}));

    // Precision clamping
    run_op(1, 1'b0, 0, got);
    run_op(15, 1'b1, 1, got);

    // Randomized operations
    for (int i = 0; i < 6; i++)
      run_op(int'($urandom_range(15, 0)), 1'($urandom), int'($urandom_range(3, 0)), got);

    // Backpressure with two back-to-back inputs
    ready_i = 1'b0;
    issue(4, 1'b0, 0, base_a, da);
    check_stream(4, 1'b0, da);
    wait_valid(lat);
    chk("bp_latency", W'(lat), W'(6));
    exp_a = ref_vec(base_a, 4, 0);
    chk("bp_first", W'(dout), exp_a);
    issue(5, 1'b1, 1, base_b, db);
    exp_b = ref_vec(base_b, 5, 1);
    for (int i = 0; i < 20; i++) begin
      chk("bp_hold_valid", W'(valid_o), W'(1'b1));
      chk("bp_hold_data", W'(dout), exp_a);
      @(negedge clk);
    end
    chk("bp_ready_low", W'(ready_o), W'(1'b0));
    ready_i = 1'b1;
    @(negedge clk);
    chk("bp_second_valid", W'(valid_o), W'(1'b1));
    chk("bp_second_data", W'(dout), exp_b);
    @(negedge clk);
    chk("bp_drained", W'(valid_o), W'(1'b0));
    chk("bp_ready_back", W'(ready_o), W'(1'b1));

    // Reset in the second STREAM cycle
    issue(6, 1'b0, 0, base_a, da);
    @(negedge clk);
    nrst = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    chk("abort_mac_en", W'(ta.mac_en), W'(1'b0));
    @(negedge clk);
    chk("abort_ready", W'(ready_o), W'(1'b1));
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (valid_o !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    chk("abort_no_valid", W'(seen), W'(1'b0));
    run_op(3, 1'b1, 2, got);

    // Accumulator wrap on the 8-bit instance
    t = 0;
    while (ready8_o !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    cfg8.n_bits = 4'd8; cfg8.signed_mode = 1'b0; cfg8.adc_ref_range_shifts = 3'd0;
    for (int e = 0; e < NE; e++) din8[e] = 8'($urandom);
    mac_valid8 = 1'b1;
    @(negedge clk);
    mac_valid8 = 1'b0;
    t = 0;
    while (valid8_o !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    chk("wrap_valid", W'(valid8_o), W'(1'b1));
    chk("wrap_result", W'(dout8), W'({NO{8'd249}}));

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
